router_pkt_tx: RTL and testbench

Packet source for the 1x3 router input port. Buffers payload bytes written by the host, and on command serialises one packet onto the router's `data_in`/`pkt_valid` interface: header, payload bytes, then parity byte. It honours the router's `busy` back-pressure, so the packet can be held mid-stream. It is the transmitting end of the protocol that `router_reg` and the router FSM receive, used both as the upstream agent in system tests and as the host-side injector in the SoC.

---
 rtl/router_pkt_tx.sv | 204 ++++++++++++++++++++
 tb/tb_router_pkt_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: host-side packet source for the 1x3 router input port.
// Payload bytes are buffered in a circular FIFO. On `start` one packet is
// serialised as header {len,dest}, payload bytes, then the parity byte.
// The router's `busy` signal holds the byte currently presented.
module router_pkt_tx #(
  parameter int DEPTH = 64  // power of two, >= 63; `count` is 7 bits so <= 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       wr_full,
  output logic [6:0] count,
  input  logic       start,
  input  logic [1:0] dest,
  input  logic [5:0] len,
  input  logic       inject_err,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       ready,
  output logic       done,
  output logic       reject
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2,
    S_PARITY  = 2'd3
  } state_t;

  // Payload storage and pointers (one bit wider than the address so that
  // full and empty are distinguishable).
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [6:0]  count_q, count_d;
  logic        wr_full_q, wr_full_d;
  logic        wr_accept;
  logic        pop;
  logic [7:0]  head_byte;

  // Packet sequencing state.
  state_t      state_q, state_d;
  logic [5:0]  rem_q, rem_d;      // payload bytes still to be loaded
  logic        err_q, err_d;      // latched inject_err
  logic [7:0]  parity_q, parity_d;

  // Registered outputs.
  logic [7:0]  data_out_q, data_out_d;
  logic        pkt_valid_q, pkt_valid_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        reject_q, reject_d;

  // A write while full is dropped; the full flag is the registered one.
  assign wr_accept = wr_en & ~wr_full_q;
  assign head_byte = mem[rd_ptr_q[AW-1:0]];

  // Buffer storage: plain write port, no reset so it maps onto RAM.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  // Pointer, occupancy and full-flag next-state.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_accept, pop})
      2'b10:   count_d = count_q + 7'd1;
      2'b01:   count_d = count_q - 7'd1;
      default: count_d = count_q;
    endcase
    wr_full_d = (count_d == 7'(DEPTH));
  end

  // Packet FSM: next state, datapath updates and output values.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    err_d       = err_q;
    parity_d    = parity_q;
    data_out_d  = data_out_q;
    pkt_valid_d = pkt_valid_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    reject_d    = 1'b0;
    pop         = 1'b0;

    case (state_q)
      S_IDLE: begin
        data_out_d  = 8'd0;
        pkt_valid_d = 1'b0;
        ready_d     = 1'b1;
        if (start) begin
          // Only accept when the destination exists and the whole payload
          // is already buffered, so the stream can never underflow.
          if ((dest != 2'd3) && ({1'b0, len} <= count_q)) begin
            state_d     = S_HEADER;
            rem_d       = len;
            err_d       = inject_err;
            parity_d    = {len, dest};
            data_out_d  = {len, dest};
            pkt_valid_d = 1'b1;
            ready_d     = 1'b0;
          end else begin
            reject_d = 1'b1;
          end
        end
      end

      // Header and payload share the advance rule: load the next payload
      // byte (popping it) or, once none remain, the parity byte.
      S_HEADER, S_PAYLOAD: begin
        if (!busy) begin
          if (rem_q == 6'd0) begin
            state_d     = S_PARITY;
            data_out_d  = parity_q ^ {8{err_q}};
            pkt_valid_d = 1'b0;
          end else begin
            state_d     = S_PAYLOAD;
            pop         = 1'b1;
            data_out_d  = head_byte;
            parity_d    = parity_q ^ head_byte;
            rem_d       = rem_q - 6'd1;
            pkt_valid_d = 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (!busy) begin
          state_d     = S_IDLE;
          data_out_d  = 8'd0;
          pkt_valid_d = 1'b0;
          ready_d     = 1'b1;
          done_d      = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        data_out_d  = 8'd0;
        pkt_valid_d = 1'b0;
        ready_d     = 1'b1;
      end
    endcase
  end

  // State, pointer and output registers; reset empties the buffer and
  // abandons any packet in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= 7'd0;
      wr_full_q   <= 1'b0;
      rem_q       <= 6'd0;
      err_q       <= 1'b0;
      parity_q    <= 8'd0;
      data_out_q  <= 8'd0;
      pkt_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      reject_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_full_q   <= wr_full_d;
      rem_q       <= rem_d;
      err_q       <= err_d;
      parity_q    <= parity_d;
      data_out_q  <= data_out_d;
      pkt_valid_q <= pkt_valid_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      reject_q    <= reject_d;
    end
  end

  assign wr_full   = wr_full_q;
  assign count     = count_q;
  assign data_out  = data_out_q;
  assign pkt_valid = pkt_valid_q;
  assign ready     = ready_q;
  assign done      = done_q;
  assign reject    = reject_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Testbench for router_pkt_tx: per-cycle expected bytes are queued when a
// packet is launched and popped as the DUT presents them.
module tb_router_pkt_tx;

  logic       clock;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_full;
  logic [6:0] count;
  logic       start;
  logic [1:0] dest;
  logic [5:0] len;
  logic       inject_err;
  logic       busy;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       ready;
  logic       done;
  logic       reject;

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       done_f;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_fifo[$];
  int         vectors = 0;
  int         miscompares = 0;

  router_pkt_tx #(.DEPTH(64)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(wr_full), .count(count), .start(start), .dest(dest), .len(len),
    .inject_err(inject_err), .busy(busy), .data_out(data_out),
    .pkt_valid(pkt_valid), .ready(ready), .done(done), .reject(reject)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic busy_in(input int c, input int at, input int n);
    return (at >= 0) && (c >= at) && (c < at + n);
  endfunction

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
    if (model_fifo.size() < 64) model_fifo.push_back(b);
  endtask

  task automatic check_idle(input string name, input logic exp_reject);
    vectors++;
    if (reject !== exp_reject || ready !== 1'b1 || pkt_valid !== 1'b0 ||
        data_out !== 8'h00 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: reject=%b ready=%b pkt_valid=%b data_out=%h done=%b, expected reject=%b ready=1 pkt_valid=0 data_out=00 done=0",
               name, reject, ready, pkt_valid, data_out, done, exp_reject);
    end
  endtask

  task automatic check_count(input string name);
    vectors++;
    if (count !== 7'(model_fifo.size()) || wr_full !== (model_fifo.size() == 64)) begin
      miscompares++;
      $display("FAIL %s: count=%0d wr_full=%b, expected count=%0d wr_full=%b",
               name, count, wr_full, model_fifo.size(), model_fifo.size() == 64);
    end
  endtask

  // Launch one packet and compare every output cycle up to the done pulse.
  // Returns in the done cycle, so a following call starts back-to-back.
  task automatic run_packet(input string name, input logic [1:0] d, input logic [5:0] l,
                            input logic e, input int busy_at, input int busy_n);
    logic [7:0] bytes[$];
    logic [7:0] par;
    logic [7:0] b;
    exp_t       ent;
    int         idx;
    int         c;
    bytes.push_back({l, d});
    par = {l, d};
    for (int i = 0; i < int'(l); i++) begin
      b = model_fifo.pop_front();
      bytes.push_back(b);
      par = par ^ b;
    end
    bytes.push_back(e ? ~par : par);
    idx = 0;
    c   = 0;
    while (idx < bytes.size()) begin
      ent.data   = bytes[idx];
      ent.valid  = (idx < bytes.size() - 1);
      ent.done_f = 1'b0;
      exp_q.push_back(ent);
      if (!busy_in(c, busy_at, busy_n)) idx++;
      c++;
    end
    ent.data   = 8'h00;
    ent.valid  = 1'b0;
    ent.done_f = 1'b1;
    exp_q.push_back(ent);

    dest       = d;
    len        = l;
    inject_err = e;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    inject_err = 1'b0;

    c = 0;
    while (exp_q.size() > 0) begin
      ent = exp_q.pop_front();
      vectors++;
      if (data_out !== ent.data || pkt_valid !== ent.valid ||
          done !== ent.done_f || ready !== ent.done_f) begin
        miscompares++;
        $display("FAIL %s cycle %0d: data_out=%h pkt_valid=%b done=%b ready=%b, expected %h %b %b %b",
                 name, c, data_out, pkt_valid, done, ready,
                 ent.data, ent.valid, ent.done_f, ent.done_f);
      end else begin
        $display("%s cycle %0d: data_out=%h pkt_valid=%b done=%b", name, c, data_out, pkt_valid, done);
      end
      if (!ent.done_f) begin
        busy = busy_in(c, busy_at, busy_n);
        tick();
      end
      c++;
    end
    busy = 1'b0;
    check_count({name, "_count"});
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    check_idle("reset_outputs", 1'b0);
    check_count("reset_count");
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    write_byte(8'h07);
    write_byte(8'h08);
    write_byte(8'h01);
    check_count("basic_count_before");
    run_packet("basic", 2'd1, 6'd3, 1'b0, -1, 0);
  endtask

  task automatic test_busy();
    write_byte(8'h07);
    write_byte(8'h08);
    write_byte(8'h01);
    run_packet("busy_hold", 2'd1, 6'd3, 1'b0, 2, 2);
  endtask

  task automatic test_inject_err();
    write_byte(8'h07);
    write_byte(8'h08);
    write_byte(8'h01);
    run_packet("inject_err", 2'd1, 6'd3, 1'b1, -1, 0);
    run_packet("len0", 2'd2, 6'd0, 1'b0, -1, 0);
    run_packet("len0_busy", 2'd0, 6'd0, 1'b0, 0, 3);
  endtask

  task automatic test_reject();
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    tick();
    dest  = 2'd0;
    len   = 6'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_idle("reject_len", 1'b1);
    tick();
    check_idle("reject_len_after", 1'b0);
    dest  = 2'd3;
    len   = 6'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_idle("reject_dest", 1'b1);
    tick();
    check_idle("reject_dest_after", 1'b0);
    check_count("reject_count");
    run_packet("after_reject", 2'd0, 6'd3, 1'b0, -1, 0);
  endtask

  task automatic test_back_to_back();
    write_byte(8'h55);
    write_byte(8'hA3);
    write_byte(8'h3C);
    run_packet("b2b_first", 2'd2, 6'd1, 1'b0, -1, 0);
    run_packet("b2b_second", 2'd1, 6'd2, 1'b0, 1, 1);
  endtask

  task automatic test_full();
    for (int i = 0; i < 63; i++) write_byte(8'(i * 3 + 1));
    check_count("full_63");
    write_byte(8'hF0);
    check_count("full_64");
    write_byte(8'hAA);
    check_count("full_65_dropped");
    run_packet("full_len63", 2'd0, 6'd63, 1'b0, 10, 2);
    run_packet("full_last", 2'd2, 6'd1, 1'b0, -1, 0);
  endtask

  task automatic test_reset_mid();
    write_byte(8'h9A);
    write_byte(8'h4B);
    write_byte(8'hC7);
    write_byte(8'h12);
    dest  = 2'd1;
    len   = 6'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    check_idle("reset_mid_outputs", 1'b0);
    model_fifo.delete();
    check_count("reset_mid_count");
    tick();
    reset = 1'b0;
    tick();
    write_byte(8'h81);
    write_byte(8'h18);
    run_packet("after_reset_mid", 2'd2, 6'd2, 1'b0, -1, 0);
  endtask

  initial begin
    reset      = 1'b1;
    wr_en      = 1'b0;
    wr_data    = 8'h00;
    start      = 1'b0;
    dest       = 2'd0;
    len        = 6'd0;
    inject_err = 1'b0;
    busy       = 1'b0;
    test_reset();
    test_basic();
    test_busy();
    test_inject_err();
    test_reject();
    test_back_to_back();
    test_full();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
